gshare_predictor_unit: RTL and testbench



---
 rtl/apogeo_pkg.sv | 6 +
 rtl/predictor_fifo.sv | 40 ++++
 rtl/gshare_predictor_unit.sv | 106 ++++++++++
 tb/tb_gshare_predictor_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apogeo_pkg.sv
// apogeo_pkg: shared ApogeoRV front-end types for the gshare predictor.
// The FIFO entry struct is declared inside the top module because its field widths come from module parameters.
package apogeo_pkg;
  typedef logic [31:0] data_word_t;
  typedef enum logic {INIT, RUN} pred_state_t;
endpackage

// File: rtl/predictor_fifo.sv
// predictor_fifo: generic in-flight FIFO with head read-out, simultaneous push/pop and synchronous clear.
module predictor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= push_i ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= pop_i ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= r_count + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk_i)
    if (push_i && !clear_i) r_mem[r_wr_ptr] <= data_i;
endmodule

// File: rtl/gshare_predictor_unit.sv
// gshare_predictor_unit: gshare direction predictor with in-flight checkpoint FIFO and post-reset table clear.
// Optional PREDICTOR_STATS_EN adds saturating prediction/misprediction counters.
module gshare_predictor_unit import apogeo_pkg::*; #(
  parameter int TABLE_SIZE   = 1024,
  parameter int HISTORY_BITS = 10,
  parameter int COUNTER_BITS = 2,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       predict_i,
  input  data_word_t fetch_address_i,
  input  data_word_t btb_address_i,
  input  logic       executed_i,
  input  logic       taken_i,
  input  logic       jump_i,
  input  data_word_t exu_address_i,
  output logic       prediction_o,
  output logic       mispredicted_o,
  output logic       full_o,
  output logic       ready_o
`ifdef PREDICTOR_STATS_EN
  ,
  output logic [31:0] predictions_o,
  output logic [31:0] mispredictions_o
`endif
);
  localparam int IW = $clog2(TABLE_SIZE);
  localparam logic [COUNTER_BITS-1:0] WEAK_NT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] CMAX = '1;
  typedef struct packed {
    logic                    pred;
    logic [IW-1:0]           index;
    data_word_t              target;
    logic [HISTORY_BITS-1:0] hist;
  } entry_t;
  pred_state_t r_state, w_state_next;
  logic [IW-1:0] r_init_idx, w_index;
  logic [HISTORY_BITS-1:0] r_spec_hist, r_commit_hist, w_spec_next, w_commit_next;
  logic [COUNTER_BITS-1:0] r_table [TABLE_SIZE];
  logic [COUNTER_BITS-1:0] w_ctr_old, w_ctr_new;
  logic w_run, w_push, w_pull, w_empty, w_fifo_full, w_outcome, w_unused;
  entry_t w_head, w_new;
  assign w_run          = r_state == RUN;
  assign ready_o        = w_run;
  assign full_o         = w_fifo_full | !w_run;
  assign w_index        = IW'(r_spec_hist) ^ fetch_address_i[IW+1:2];
  assign w_unused       = ^{fetch_address_i[31:IW+2], fetch_address_i[1:0]};
  assign prediction_o   = w_run & predict_i & r_table[w_index][COUNTER_BITS-1];
  assign w_outcome      = taken_i | jump_i;
  assign w_pull         = w_run & executed_i & !w_empty;
  assign mispredicted_o = w_pull & !flush_i & ((w_outcome != w_head.pred) | (w_head.target != exu_address_i));
  assign w_push         = w_run & predict_i & !stall_i & !full_o & !mispredicted_o & !flush_i;
  assign w_new          = '{prediction_o, w_index, btb_address_i, r_spec_hist};
  assign w_ctr_old      = r_table[w_head.index];
  assign w_ctr_new      = w_outcome ? (w_ctr_old == CMAX ? w_ctr_old : w_ctr_old + 1'b1)
                                    : (w_ctr_old == '0 ? w_ctr_old : w_ctr_old - 1'b1);
  assign w_commit_next  = w_pull ? HISTORY_BITS'({r_commit_hist, w_outcome}) : r_commit_hist;
  // flush repairs from committed history, a mispredict from the offending entry's checkpoint
  assign w_spec_next    = flush_i        ? w_commit_next
                        : mispredicted_o ? HISTORY_BITS'({w_head.hist, w_outcome})
                        : w_push         ? HISTORY_BITS'({r_spec_hist, prediction_o})
                        : r_spec_hist;
  always_comb w_state_next = (r_state == INIT && r_init_idx == IW'(TABLE_SIZE - 1)) ? RUN : r_state;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state       <= INIT;
      r_init_idx    <= '0;
      r_spec_hist   <= '0;
      r_commit_hist <= '0;
    end else begin
      r_state       <= w_state_next;
      r_init_idx    <= w_run ? r_init_idx : r_init_idx + 1'b1;
      r_spec_hist   <= w_spec_next;
      r_commit_hist <= w_commit_next;
    end
  always_ff @(posedge clk_i)
    if (!w_run) r_table[r_init_idx] <= WEAK_NT;
    else if (w_pull) r_table[w_head.index] <= w_ctr_new;
  predictor_fifo #(.WIDTH($bits(entry_t)), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i | mispredicted_o),
    .push_i  (w_push),
    .pop_i   (w_pull),
    .data_i  (w_new),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_empty)
  );
`ifdef PREDICTOR_STATS_EN
  logic [31:0] r_predictions, r_mispredictions;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_predictions    <= '0;
      r_mispredictions <= '0;
    end else begin
      r_predictions    <= (w_push && r_predictions != '1) ? r_predictions + 1'b1 : r_predictions;
      r_mispredictions <= (mispredicted_o && r_mispredictions != '1) ? r_mispredictions + 1'b1 : r_mispredictions;
    end
  assign predictions_o    = r_predictions;
  assign mispredictions_o = r_mispredictions;
`endif
endmodule

// File: tb/tb_gshare_predictor_unit.sv
// tb_gshare_predictor_unit: directed table, corner sequences and random traffic against a queue-based predictor model.
module tb_gshare_predictor_unit;
  localparam int TS = 1024;
  localparam int HB = 10;
  localparam int DEPTH = 8;
  localparam int HMASK = (1 << HB) - 1;
  logic clk = 0, rst = 1, stall = 0, flush = 0, predict = 0, executed = 0, taken = 0, jump = 0;
  logic [31:0] pc = 0, btb = 0, exu = 0;
  logic pred_o, mis_o, full_o, ready_o;
`ifdef PREDICTOR_STATS_EN
  logic [31:0] npred_o, nmis_o;
`endif
  gshare_predictor_unit dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .predict_i(predict),
    .fetch_address_i(pc), .btb_address_i(btb), .executed_i(executed), .taken_i(taken),
    .jump_i(jump), .exu_address_i(exu), .prediction_o(pred_o), .mispredicted_o(mis_o),
    .full_o(full_o), .ready_o(ready_o)
`ifdef PREDICTOR_STATS_EN
    , .predictions_o(npred_o), .mispredictions_o(nmis_o)
`endif
  );
  always #5 clk = ~clk;

  typedef struct { bit pred; int idx; logic [31:0] tgt; int hist; } ent_t;
  typedef struct { bit pr; logic [31:0] a; logic [31:0] t; bit ex; bit tk; bit jp; logic [31:0] ea; bit exp_pred; bit exp_mis; } vec_t;
  ent_t q[$];
  int tbl[TS];
  int sh, ch, m_npred, m_nmis;
  int n_cmp = 0, n_bad = 0;
  logic s_pred, s_mis;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (tbl[i]) tbl[i] = 1;
    sh = 0; ch = 0; m_npred = 0; m_nmis = 0;
    q.delete();
  endtask

  task automatic drive(bit pr, logic [31:0] a, logic [31:0] t, bit ex, bit tk, bit jp, logic [31:0] ea);
    predict = pr; pc = a; btb = t; executed = ex; taken = tk; jump = jp; exu = ea; stall = 0; flush = 0;
  endtask

  // one clock: compare against the model with inputs already driven, then advance the model
  task automatic step(string tag);
    int idx;
    bit p, m, pl, pu, oc;
    ent_t e;
    #1;
    idx = sh ^ ((pc >> 2) & (TS - 1));
    p = predict && tbl[idx] >= 2;
    pl = executed && q.size() != 0;
    oc = taken || jump;
    e = '{0, 0, 0, 0};
    if (pl) e = q[0];
    m = pl && !flush && (oc != e.pred || e.tgt != exu);
    pu = predict && !stall && q.size() < DEPTH && !m && !flush;
    s_pred = pred_o; s_mis = mis_o;
    if (predict) chk({tag, ".pred"}, pred_o, p);
    chk({tag, ".mis"}, mis_o, m);
    chk({tag, ".full"}, full_o, q.size() == DEPTH);
    chk({tag, ".ready"}, ready_o, 1);
    if (pl) begin
      tbl[e.idx] = oc ? (tbl[e.idx] == 3 ? 3 : tbl[e.idx] + 1) : (tbl[e.idx] == 0 ? 0 : tbl[e.idx] - 1);
      ch = ((ch << 1) | oc) & HMASK;
      void'(q.pop_front());
    end
    if (pu) begin
      q.push_back('{p, idx, btb, sh});
      sh = ((sh << 1) | p) & HMASK;
      m_npred++;
    end
    if (m) m_nmis++;
    if (flush) begin
      q.delete();
      sh = ch;
    end else if (m) begin
      q.delete();
      sh = ((e.hist << 1) | oc) & HMASK;
    end
    @(negedge clk);
  endtask

  // entered at the negedge where reset was just released
  task automatic init_phase();
    for (int k = 0; k < TS; k++) begin
      predict = 1'($urandom_range(1, 0)); executed = 1'($urandom_range(1, 0));
      flush = (k == 300); pc = $urandom; taken = 1; exu = $urandom;
      #1;
      chk("init.ready", ready_o, 0);
      chk("init.full", full_o, 1);
      chk("init.pred", pred_o, 0);
      chk("init.mis", mis_o, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("init.done_ready", ready_o, 1);
    chk("init.done_full", full_o, 0);
    @(negedge clk);
  endtask

  task automatic resolve_head(string tag, bit also_push);
    drive(also_push, $urandom & 32'hFFC, 32'h400, 1, q[0].pred, 0, q[0].tgt);
    step(tag);
  endtask

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 32'h100, 32'h200, 0, 0, 0, 0,       0, 0};
    vecs[1]  = '{0, 0,       0,       1, 1, 0, 32'h200, 0, 1};
    vecs[2]  = '{1, 32'h104, 32'h200, 0, 0, 0, 0,       1, 0};
    vecs[3]  = '{0, 0,       0,       1, 1, 0, 32'h200, 0, 0};
    vecs[4]  = '{1, 32'h10C, 32'h200, 0, 0, 0, 0,       1, 0};
    vecs[5]  = '{0, 0,       0,       1, 1, 0, 32'h200, 0, 0};
    vecs[6]  = '{1, 32'h11C, 32'h200, 0, 0, 0, 0,       1, 0};
    vecs[7]  = '{0, 0,       0,       1, 0, 0, 32'h104, 0, 1};
    vecs[8]  = '{1, 32'h138, 32'h200, 0, 0, 0, 0,       1, 0};
    vecs[9]  = '{0, 0,       0,       1, 1, 0, 32'h300, 0, 1};
    vecs[10] = '{1, 32'h174, 32'h200, 0, 0, 0, 0,       1, 0};
    vecs[11] = '{0, 0,       0,       1, 0, 1, 32'h200, 0, 0};
    model_reset();
    @(negedge clk);
    #1;
    chk("reset.full", full_o, 1);
    chk("reset.ready", ready_o, 0);
    chk("reset.mis", mis_o, 0);
    rst = 0;
    init_phase();

    // index stays 0x40 by cancelling the history in the PC, so one counter trains and saturates
    foreach (vecs[i]) begin
      drive(vecs[i].pr, vecs[i].a, vecs[i].t, vecs[i].ex, vecs[i].tk, vecs[i].jp, vecs[i].ea);
      step($sformatf("vec%0d", i));
      if (vecs[i].pr) chk($sformatf("vec%0d.exp_pred", i), s_pred, vecs[i].exp_pred);
      chk($sformatf("vec%0d.exp_mis", i), s_mis, vecs[i].exp_mis);
    end

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, $urandom & 32'hFFC, 32'h200 + 4 * i, 0, 0, 0, 0);
      step("fill");
    end
    #1 chk("fill.full8", full_o, 1);
    drive(1, 32'h500, 32'h999, 0, 0, 0, 0);
    step("fill.drop9");
    resolve_head("drain.first", 0);
    #1 chk("drain.full_low", full_o, 0);
    for (int i = 0; i < DEPTH - 1; i++) resolve_head("drain", 0);
    drive(0, 0, 0, 1, 1, 0, 32'hDEAD);
    step("drain.empty_exec");
    chk("drain.empty_no_mis", s_mis, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h800 + 16 * i, 32'h600, 0, 0, 0, 0);
      step("mp.push");
    end
    drive(0, 0, 0, 1, !q[0].pred, 0, q[0].tgt);
    step("mp.resolve");
    chk("mp.flagged", s_mis, 1);
    #1 chk("mp.not_full", full_o, 0);
    drive(1, 32'h100, 32'h200, 0, 0, 0, 0);
    step("mp.repaired_index");
    drive(0, 0, 0, 1, 1, 0, 32'hBEEF);
    step("mp.after");

    drive(0, 0, 0, 1, 1, 0, 32'h200);
    flush = 1;
    step("pp.flush");
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom & 32'hFFC, 32'h700, 0, 0, 0, 0);
      step("pp.push");
    end
    for (int i = 0; i < 10; i++) resolve_head("pp.both", 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom & 32'hFFC, 32'h700, 0, 0, 0, 0);
      step("pp.top");
    end
    #1 chk("pp.count7_not_full", full_o, 0);
    drive(1, $urandom & 32'hFFC, 32'h700, 0, 0, 0, 0);
    step("pp.top8");
    #1 chk("pp.count8_full", full_o, 1);

    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(9, 0) < 7), ($urandom & 32'hFFFF_0000) | ($urandom & 32'hFFC),
            32'h200 + 32'h100 * $urandom_range(2, 0), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(7, 0) == 0), 32'h200 + 32'h100 * $urandom_range(2, 0));
      if (q.size() != 0 && $urandom_range(3, 0) != 0) begin
        exu = q[0].tgt;
        taken = q[0].pred;
        jump = 0;
      end
      stall = 1'($urandom_range(9, 0) == 0);
      flush = 1'($urandom_range(31, 0) == 0);
      step("rnd");
    end

`ifdef PREDICTOR_STATS_EN
    #1;
    chk("stats.predictions", npred_o, m_npred);
    chk("stats.mispredictions", nmis_o, m_nmis);
`endif
    drive(1, 32'h100, 32'h200, 1, 1, 0, 32'h200);
    #2 rst = 1;
    #1;
    chk("midreset.full", full_o, 1);
    chk("midreset.ready", ready_o, 0);
    chk("midreset.pred", pred_o, 0);
    chk("midreset.mis", mis_o, 0);
`ifdef PREDICTOR_STATS_EN
    chk("midreset.npred", npred_o, 0);
    chk("midreset.nmis", nmis_o, 0);
`endif
    @(negedge clk);
    rst = 0;
    model_reset();
    init_phase();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(1, 0)), $urandom & 32'hFFC, 32'h200, 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 0, 32'h200);
      step("post");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
